axi_pwm_v2_0: RTL and testbench

// - AXI4-Lite slave generating NUM_CHANNELS independent PWM outputs of CNT_WIDTH resolution.
// - Successor of the v1 PWM: adds edge/center-aligned modes, output polarity, and

---
 rtl/axi_pwm_v2_0.sv | 213 +++++++++++++++++++++
 tb/tb_axi_pwm_v2_0.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_pwm_v2_0.sv
// Multi-channel PWM behind an AXI4-Lite slave. Each channel has edge/center alignment,
// output inversion, and PERIOD/DUTY shadows that reach the counter only at period boundaries.
module axi_pwm_v2_0 #(
    parameter int NUM_CHANNELS       = 6,
    parameter int CNT_WIDTH          = 16,
    parameter int C_S_AXI_ADDR_WIDTH = 32
) (
    input  logic                          s_axi_aclk,
    input  logic                          s_axi_areset,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0] s_axi_awaddr,
    input  logic [2:0]                    s_axi_awprot,
    input  logic                          s_axi_awvalid,
    output logic                          s_axi_awready,
    input  logic [31:0]                   s_axi_wdata,
    input  logic [3:0]                    s_axi_wstrb,
    input  logic                          s_axi_wvalid,
    output logic                          s_axi_wready,
    output logic [1:0]                    s_axi_bresp,
    output logic                          s_axi_bvalid,
    input  logic                          s_axi_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0] s_axi_araddr,
    input  logic [2:0]                    s_axi_arprot,
    input  logic                          s_axi_arvalid,
    output logic                          s_axi_arready,
    output logic [31:0]                   s_axi_rdata,
    output logic [1:0]                    s_axi_rresp,
    output logic                          s_axi_rvalid,
    input  logic                          s_axi_rready,
    output logic [NUM_CHANNELS-1:0]       pwm,
    output logic [NUM_CHANNELS-1:0]       period_tick
);

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    logic        wr_ready_reg, bvalid_reg, ar_ready_reg, rvalid_reg;
    logic [31:0] rdata_reg, rd_mux;
    logic        wr_fire, rd_fire;
    logic [3:0]  rd_ch;
    logic [1:0]  rd_sel;

    logic [2:0]           ctrl_arr [NUM_CHANNELS];
    logic [CNT_WIDTH-1:0] p_arr    [NUM_CHANNELS];
    logic [CNT_WIDTH-1:0] d_arr    [NUM_CHANNELS];
    logic                 pend_arr [NUM_CHANNELS];

    logic unused_ok;
    assign unused_ok = ^{s_axi_awprot, s_axi_arprot,
                         s_axi_awaddr[C_S_AXI_ADDR_WIDTH-1:8], s_axi_awaddr[1:0],
                         s_axi_araddr[C_S_AXI_ADDR_WIDTH-1:8], s_axi_araddr[1:0]};

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  strb);
        logic [31:0] res;
        for (int b = 0; b < 4; b++)
            res[b*8 +: 8] = strb[b] ? new_val[b*8 +: 8] : old_val[b*8 +: 8];
        return res;
    endfunction

    assign wr_fire = wr_ready_reg & s_axi_awvalid & s_axi_wvalid;
    assign rd_fire = ar_ready_reg & s_axi_arvalid;
    assign rd_ch   = s_axi_araddr[7:4];
    assign rd_sel  = s_axi_araddr[3:2];

    assign s_axi_awready = wr_ready_reg;
    assign s_axi_wready  = wr_ready_reg;
    assign s_axi_bvalid  = bvalid_reg;
    assign s_axi_bresp   = 2'b00;
    assign s_axi_arready = ar_ready_reg;
    assign s_axi_rvalid  = rvalid_reg;
    assign s_axi_rdata   = rdata_reg;
    assign s_axi_rresp   = 2'b00;

    // Ready pulses are single-cycle: the self-term stops a second acceptance of the same beat.
    always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
        if (s_axi_areset) begin
            wr_ready_reg <= 1'b0;
            bvalid_reg   <= 1'b0;
            ar_ready_reg <= 1'b0;
            rvalid_reg   <= 1'b0;
            rdata_reg    <= '0;
        end else begin
            wr_ready_reg <= s_axi_awvalid & s_axi_wvalid & ~bvalid_reg & ~wr_ready_reg;
            if (wr_fire)
                bvalid_reg <= 1'b1;
            else if (s_axi_bready)
                bvalid_reg <= 1'b0;

            ar_ready_reg <= s_axi_arvalid & ~rvalid_reg & ~ar_ready_reg;
            if (rd_fire) begin
                rvalid_reg <= 1'b1;
                rdata_reg  <= rd_mux;
            end else if (s_axi_rready) begin
                rvalid_reg <= 1'b0;
            end
        end
    end

    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            if (rd_ch == 4'(i)) begin
                case (rd_sel)
                    2'd0:    rd_mux = {29'd0, ctrl_arr[i]};
                    2'd1:    rd_mux = 32'(p_arr[i]);
                    2'd2:    rd_mux = 32'(d_arr[i]);
                    default: rd_mux = {31'd0, pend_arr[i]};
                endcase
            end
        end
    end

    for (genvar gi = 0; gi < NUM_CHANNELS; gi++) begin : g_ch
        logic [CNT_WIDTH-1:0] cnt_reg, pa_reg, da_reg, p_reg, d_reg, cnt_next;
        logic dir_reg, dir_next, en_reg, center_reg, inv_reg, pwm_reg, tick_reg;
        logic sel, ctrl_wr, restart, boundary;

        assign sel     = wr_fire && (s_axi_awaddr[7:4] == 4'(gi));
        assign ctrl_wr = sel && (s_axi_awaddr[3:2] == 2'd0) && s_axi_wstrb[0];
        assign restart = ctrl_wr && (s_axi_wdata[1] != center_reg);

        // dir_reg=1 means counting down in center mode; boundary marks the return to 0.
        always_comb begin
            cnt_next = cnt_reg;
            dir_next = dir_reg;
            boundary = 1'b0;
            if (!center_reg) begin
                if (cnt_reg >= pa_reg) begin
                    cnt_next = '0;
                    boundary = 1'b1;
                end else begin
                    cnt_next = cnt_reg + CNT_ONE;
                end
            end else if (!dir_reg) begin
                if (cnt_reg >= pa_reg) begin
                    if (pa_reg <= CNT_ONE) begin
                        cnt_next = '0;
                        boundary = 1'b1;
                    end else begin
                        cnt_next = pa_reg - CNT_ONE;
                        dir_next = 1'b1;
                    end
                end else begin
                    cnt_next = cnt_reg + CNT_ONE;
                end
            end else begin
                if (cnt_reg <= CNT_ONE) begin
                    cnt_next = '0;
                    dir_next = 1'b0;
                    boundary = 1'b1;
                end else begin
                    cnt_next = cnt_reg - CNT_ONE;
                end
            end
        end

        always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
            if (s_axi_areset) begin
                cnt_reg    <= '0;
                pa_reg     <= '0;
                da_reg     <= '0;
                p_reg      <= '0;
                d_reg      <= '0;
                dir_reg    <= 1'b0;
                en_reg     <= 1'b0;
                center_reg <= 1'b0;
                inv_reg    <= 1'b0;
                pwm_reg    <= 1'b0;
                tick_reg   <= 1'b0;
            end else begin
                tick_reg <= 1'b0;
                if (sel && s_axi_awaddr[3:2] == 2'd1)
                    p_reg <= CNT_WIDTH'(merge_bytes(32'(p_reg), s_axi_wdata, s_axi_wstrb));
                if (sel && s_axi_awaddr[3:2] == 2'd2)
                    d_reg <= CNT_WIDTH'(merge_bytes(32'(d_reg), s_axi_wdata, s_axi_wstrb));
                if (ctrl_wr) begin
                    en_reg     <= s_axi_wdata[0];
                    center_reg <= s_axi_wdata[1];
                    inv_reg    <= s_axi_wdata[2];
                end

                // Active values only move on a boundary, so a shadow written in the same
                // cycle lands one period later; while disabled they track the shadows.
                if (!en_reg) begin
                    cnt_reg <= '0;
                    dir_reg <= 1'b0;
                    pa_reg  <= p_reg;
                    da_reg  <= d_reg;
                end else if (restart) begin
                    cnt_reg <= '0;
                    dir_reg <= 1'b0;
                end else begin
                    cnt_reg <= cnt_next;
                    dir_reg <= dir_next;
                    if (boundary) begin
                        pa_reg   <= p_reg;
                        da_reg   <= d_reg;
                        tick_reg <= 1'b1;
                    end
                end
                pwm_reg <= (en_reg & (cnt_reg < da_reg)) ^ inv_reg;
            end
        end

        assign pwm[gi]         = pwm_reg;
        assign period_tick[gi] = tick_reg;
        assign ctrl_arr[gi]    = {inv_reg, center_reg, en_reg};
        assign p_arr[gi]       = p_reg;
        assign d_arr[gi]       = d_reg;
        assign pend_arr[gi]    = (p_reg != pa_reg) || (d_reg != da_reg);
    end

endmodule

// File: tb/tb_axi_pwm_v2_0.sv
// Directed bench for axi_pwm_v2_0: register access, edge/center waveforms, shadow commit,
// unmapped channels, early wvalid, and asynchronous reset during activity.
module tb_axi_pwm_v2_0;

    localparam int NCH = 6;
    localparam int CW  = 16;
    localparam int AW  = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [AW-1:0] awaddr = '0;
    logic [2:0]    awprot = 3'd0;
    logic          awvalid = 1'b0;
    logic          awready;
    logic [31:0]   wdata = '0;
    logic [3:0]    wstrb = 4'h0;
    logic          wvalid = 1'b0;
    logic          wready;
    logic [1:0]    bresp;
    logic          bvalid;
    logic          bready = 1'b0;
    logic [AW-1:0] araddr = '0;
    logic [2:0]    arprot = 3'd0;
    logic          arvalid = 1'b0;
    logic          arready;
    logic [31:0]   rdata;
    logic [1:0]    rresp;
    logic          rvalid;
    logic          rready = 1'b0;
    logic [NCH-1:0] pwm;
    logic [NCH-1:0] period_tick;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    axi_pwm_v2_0 #(.NUM_CHANNELS(NCH), .CNT_WIDTH(CW), .C_S_AXI_ADDR_WIDTH(AW)) dut (
        .s_axi_aclk(clk), .s_axi_areset(rst),
        .s_axi_awaddr(awaddr), .s_axi_awprot(awprot), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
        .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
        .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
        .s_axi_araddr(araddr), .s_axi_arprot(arprot), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
        .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
        .pwm(pwm), .period_tick(period_tick)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
        int n;
        awaddr = addr; wdata = data; wstrb = strb;
        awvalid = 1'b1; wvalid = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!awready && n < 20);
        check("wr awready", 32'(awready), 32'd1);
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0;
        check("wr bvalid", 32'(bvalid), 32'd1);
        check("wr bresp", 32'(bresp), 32'd0);
        bready = 1'b1;
        @(negedge clk);
        bready = 1'b0;
        $display("wr 0x%02h <= 0x%08h strb %b", addr[7:0], data, strb);
    endtask

    task automatic axi_read(input logic [31:0] addr, output logic [31:0] data);
        int n;
        araddr = addr; arvalid = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!arready && n < 20);
        check("rd arready", 32'(arready), 32'd1);
        @(negedge clk);
        arvalid = 1'b0;
        check("rd rvalid", 32'(rvalid), 32'd1);
        data = rdata;
        rready = 1'b1;
        @(negedge clk);
        rready = 1'b0;
        $display("rd 0x%02h => 0x%08h", addr[7:0], data);
    endtask

    task automatic read_check(input logic [31:0] addr, input logic [31:0] exp, input string tag);
        logic [31:0] d;
        axi_read(addr, d);
        check(tag, d, exp);
    endtask

    // Sync to a commit pulse, then sample 32 cycles: every test uses a 16-cycle period.
    task automatic expect_pwm(input int ch, input string tag, input int exp_highs, input logic [15:0] exp_pat);
        int highs, ticks, gap, k;
        logic [15:0] pat;
        highs = 0; ticks = 0; gap = -1; pat = '0; k = 0;
        do begin @(negedge clk); k++; end while (!period_tick[ch] && k < 200);
        check({tag, " sync"}, 32'(period_tick[ch]), 32'd1);
        for (int i = 1; i <= 32; i++) begin
            @(negedge clk);
            if (pwm[ch]) highs++;
            if (i <= 16) pat[i-1] = pwm[ch];
            if (period_tick[ch]) begin
                ticks++;
                if (gap < 0) gap = i;
            end
        end
        check({tag, " highs"}, 32'(highs), 32'(exp_highs));
        check({tag, " pattern"}, 32'(pat), 32'(exp_pat));
        check({tag, " ticks"}, 32'(ticks), 32'd2);
        check({tag, " period"}, 32'(gap), 32'd16);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, highs, ticks3;
        repeat (3) @(negedge clk);
        check("rst pwm", 32'(pwm), 32'd0);
        check("rst tick", 32'(period_tick), 32'd0);
        check("rst ready", 32'({awready, wready, arready}), 32'd0);
        check("rst valid", 32'({bvalid, rvalid}), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        read_check(32'h00, 32'd0, "rst ch0 ctrl");
        read_check(32'h0C, 32'd0, "rst ch0 status");

        // Ch0 edge: P=15 D=4
        axi_write(32'h04, 32'd15, 4'hF);
        axi_write(32'h08, 32'd4, 4'hF);
        axi_write(32'h00, 32'd1, 4'hF);
        read_check(32'h04, 32'd15, "ch0 period rb");
        expect_pwm(0, "ch0 edge d4", 8, 16'h000F);

        // Ch1 constant low/high, then inverted
        axi_write(32'h14, 32'd15, 4'hF);
        axi_write(32'h18, 32'd0, 4'hF);
        axi_write(32'h10, 32'd1, 4'hF);
        expect_pwm(1, "ch1 d0", 0, 16'h0000);
        axi_write(32'h18, 32'd16, 4'hF);
        expect_pwm(1, "ch1 d16", 32, 16'hFFFF);
        axi_write(32'h10, 32'd5, 4'hF);
        expect_pwm(1, "ch1 d16 inv", 0, 16'h0000);
        axi_write(32'h18, 32'd0, 4'hF);
        expect_pwm(1, "ch1 d0 inv", 32, 16'hFFFF);

        // Ch2 center: P=8 D=3 -> 5 high cycles around cnt=0
        axi_write(32'h24, 32'd8, 4'hF);
        axi_write(32'h28, 32'd3, 4'hF);
        axi_write(32'h20, 32'd3, 4'hF);
        expect_pwm(2, "ch2 center", 10, 16'hC007);

        // Ch0 duty change mid-period
        k = 0;
        do begin @(negedge clk); k++; end while (!period_tick[0] && k < 100);
        check("ch0 tick sync", 32'(period_tick[0]), 32'd1);
        axi_write(32'h08, 32'd10, 4'hF);
        read_check(32'h0C, 32'd1, "ch0 pend set");
        highs = 0; k = 0;
        do begin
            @(negedge clk); k++;
            if (pwm[0]) highs++;
        end while (!period_tick[0] && k < 40);
        check("ch0 old duty tail", 32'(highs), 32'd0);
        check("ch0 boundary", 32'(period_tick[0]), 32'd1);
        read_check(32'h0C, 32'd0, "ch0 pend clear");
        expect_pwm(0, "ch0 edge d10", 20, 16'h03FF);

        // Unmapped channel 7
        axi_write(32'h70, 32'hFFFF_FFFF, 4'hF);
        axi_write(32'h74, 32'h0000_1234, 4'hF);
        read_check(32'h70, 32'd0, "ch7 ctrl rd");
        read_check(32'h74, 32'd0, "ch7 period rd");
        read_check(32'h30, 32'd0, "ch3 ctrl untouched");
        repeat (4) @(negedge clk);
        check("ch3-5 pwm idle", 32'(pwm[5:3]), 32'd0);

        // wvalid two cycles ahead of awvalid, wide data truncated
        wdata = 32'hDEAD_BEEF; wstrb = 4'hF; wvalid = 1'b1; awaddr = 32'h34;
        @(negedge clk);
        check("early w ready1", 32'({awready, wready}), 32'd0);
        @(negedge clk);
        check("early w ready2", 32'({awready, wready}), 32'd0);
        awvalid = 1'b1;
        k = 0;
        do begin @(negedge clk); k++; end while (!awready && k < 20);
        check("early w handshake", 32'({awready, wready}), 32'd3);
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0;
        check("early w single", 32'(awready), 32'd0);
        check("early w bvalid", 32'(bvalid), 32'd1);
        bready = 1'b1;
        @(negedge clk);
        bready = 1'b0;
        check("early w bvalid clr", 32'(bvalid), 32'd0);
        $display("wr 0x34 <= 0xdeadbeef strb 1111 (wvalid early)");
        read_check(32'h34, 32'h0000_BEEF, "ch3 period trunc");

        // Byte strobes
        axi_write(32'h38, 32'h0000_1234, 4'hF);
        axi_write(32'h38, 32'h0000_AB00, 4'h2);
        read_check(32'h38, 32'h0000_AB34, "ch3 duty strb");
        axi_write(32'h30, 32'h0000_0004, 4'h2);
        read_check(32'h30, 32'd0, "ch3 ctrl strb off");
        axi_write(32'h30, 32'hFFFF_FFF4, 4'h1);
        read_check(32'h30, 32'd4, "ch3 ctrl mask");

        // Disabled + INV: constant high, no ticks
        ticks3 = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (period_tick[3]) ticks3++;
        end
        check("ch3 dis inv pwm", 32'(pwm[3]), 32'd1);
        check("ch3 dis ticks", 32'(ticks3), 32'd0);

        // Reset during a write with channels running
        check("pre-rst ch1 high", 32'(pwm[1]), 32'd1);
        awaddr = 32'h24; wdata = 32'h33; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        k = 0;
        do begin @(negedge clk); k++; end while (!awready && k < 20);
        rst = 1'b1;
        #1;
        check("mid rst pwm", 32'(pwm), 32'd0);
        check("mid rst tick", 32'(period_tick), 32'd0);
        check("mid rst ready", 32'({awready, wready}), 32'd0);
        check("mid rst bvalid", 32'(bvalid), 32'd0);
        awvalid = 1'b0; wvalid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("post rst valid", 32'({bvalid, rvalid}), 32'd0);
        read_check(32'h00, 32'd0, "post rst ch0 ctrl");
        read_check(32'h04, 32'd0, "post rst ch0 period");
        read_check(32'h08, 32'd0, "post rst ch0 duty");
        read_check(32'h10, 32'd0, "post rst ch1 ctrl");
        read_check(32'h24, 32'd0, "post rst ch2 period");
        read_check(32'h34, 32'd0, "post rst ch3 period");
        check("post rst pwm", 32'(pwm), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
